// File: rtl/rr_pkt_pkg.sv
// Shared definitions for the packet-granular round-robin mux.
//   NUM_REQ_DEF / DATA_W_DEF : default requester count and payload width
//   state_t                  : mux FSM states (IDLE, LOCKED)
//   beat_t                   : beat record carried through the output skid
//                              (data in the MSBs, then last, then id)
package rr_pkt_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
        logic [ID_W_DEF-1:0]   id;
    } beat_t;

    localparam int BEAT_W_DEF = $bits(beat_t);

endpackage

// File: rtl/pkt_skid_buf.sv
// Generic 2-entry valid/ready register slice.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake (in_ready = skid entry free)
//   in_data [WIDTH]       : upstream payload
//   out_valid/out_ready   : downstream handshake, out_valid registered
//   out_data [WIDTH]      : downstream payload, driven only from a register
// The first beat parks in the output register; a second beat arriving while
// the output is stalled goes to the skid entry, which then deasserts in_ready.
module pkt_skid_buf #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             skid_valid_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             push_s;
    logic             pop_s;

    // Handshake decode; in_ready depends only on registered state.
    always_comb begin
        in_ready = ~skid_valid_r;
        push_s   = in_valid & ~skid_valid_r;
        pop_s    = out_valid_r & out_ready;
    end

    // Output register and skid entry update; order is output reg then skid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {WIDTH{1'b0}};
        end else if (skid_valid_r) begin
            // No push possible while the skid is occupied.
            if (pop_s) begin
                out_data_r   <= skid_data_r;
                skid_valid_r <= 1'b0;
            end
        end else if (push_s) begin
            if (!out_valid_r || pop_s) begin
                out_data_r  <= in_data;
                out_valid_r <= 1'b1;
            end else begin
                skid_data_r  <= in_data;
                skid_valid_r <= 1'b1;
            end
        end else if (pop_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: rtl/rr_pkt_mux.sv
// Packet-granular mux behind a 4-way round-robin arbiter.
//   clk, reset       : clock, asynchronous active-high reset
//   in_valid_i/in_data_i/in_last_i/in_ready_o : per-requester beat streams,
//                      requester k data at in_data_i[k*DATA_W +: DATA_W]
//   arb_req_o / arb_gnt_i : request vector out, one-hot grant back (same cycle)
//   out_valid_o/out_ready_i/out_data_o/out_last_o/out_id_o : registered output
//   timeout_o        : sticky packet-length timeout (RR_PKT_MUX_TIMEOUT_EN only)
// Requests are presented to the arbiter only while IDLE, so the arbiter rotates
// once per packet. After a grant the mux locks onto the owner until the owner's
// last beat is transferred. Build option: `define RR_PKT_MUX_TIMEOUT_EN to cap
// packets at MAX_BEATS beats, forcing last on the final beat.
module rr_pkt_mux
    import rr_pkt_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BEATS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        in_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] in_data_i,
    input  logic [NUM_REQ-1:0]        in_last_i,
    output logic [NUM_REQ-1:0]        in_ready_o,
    output logic [NUM_REQ-1:0]        arb_req_o,
    input  logic [NUM_REQ-1:0]        arb_gnt_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_W-1:0]         out_data_o,
    output logic                      out_last_o,
`ifdef RR_PKT_MUX_TIMEOUT_EN
    output logic [$clog2(NUM_REQ)-1:0] out_id_o,
    output logic                       timeout_o
`else
    output logic [$clog2(NUM_REQ)-1:0] out_id_o
`endif
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int BEAT_W = DATA_W + 1 + ID_W;

    state_t              state_r;
    logic [ID_W-1:0]     owner_r;
    logic                owner_valid_s;
    logic                owner_last_s;
    logic [DATA_W-1:0]   owner_data_s;
    logic                last_eff_s;
    logic                take_s;
    logic                skid_ready_s;
    logic                skid_full_s;
    logic [BEAT_W-1:0]   beat_s;
    logic [BEAT_W-1:0]   skid_out_s;

    // Index of the lowest set bit; a malformed multi-hot grant resolves low.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign skid_full_s = ~skid_ready_s;

    // Select the owner's beat stream.
    always_comb begin
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        owner_data_s  = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_r == ID_W'(k)) begin
                owner_valid_s = in_valid_i[k];
                owner_last_s  = in_last_i[k];
                owner_data_s  = in_data_i[k*DATA_W +: DATA_W];
            end else begin
                owner_valid_s = owner_valid_s;
            end
        end
    end

    // Arbiter requests and input accepts per state; IDLE never accepts a beat.
    always_comb begin
        arb_req_o  = {NUM_REQ{1'b0}};
        in_ready_o = {NUM_REQ{1'b0}};
        take_s     = 1'b0;
        case (state_r)
            IDLE: begin
                arb_req_o = in_valid_i;
            end
            LOCKED: begin
                in_ready_o[owner_r] = ~skid_full_s;
                take_s              = owner_valid_s & ~skid_full_s;
            end
            default: begin
                arb_req_o = {NUM_REQ{1'b0}};
            end
        endcase
    end

`ifdef RR_PKT_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [CNT_W-1:0] beat_cnt_r;
    logic             timeout_r;
    logic             cnt_hit_s;

    assign cnt_hit_s  = (beat_cnt_r == CNT_W'(MAX_BEATS - 1));
    assign last_eff_s = owner_last_s | cnt_hit_s;
    assign timeout_o  = timeout_r;

    // Beats transferred in the current packet, plus the sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_r <= {CNT_W{1'b0}};
            timeout_r  <= 1'b0;
        end else if (state_r == IDLE) begin
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (take_s) begin
            if (last_eff_s) begin
                beat_cnt_r <= {CNT_W{1'b0}};
            end else begin
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
            if (cnt_hit_s && !owner_last_s) begin
                timeout_r <= 1'b1;
            end
        end
    end
`else
    // MAX_BEATS only matters when the timeout is built in.
    logic unused_cfg_s;
    assign unused_cfg_s = (MAX_BEATS > 0);
    assign last_eff_s   = owner_last_s;
`endif

    // Packet lock FSM: grant in IDLE locks the owner, its last beat unlocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (|arb_gnt_i) begin
                        owner_r <= lowest_idx(arb_gnt_i);
                        state_r <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (take_s && last_eff_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Beat record in beat_t field order: data, last, id.
    assign beat_s = {owner_data_s, last_eff_s, owner_r};

    pkt_skid_buf #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (take_s),
        .in_ready  (skid_ready_s),
        .in_data   (beat_s),
        .out_valid (out_valid_o),
        .out_ready (out_ready_i),
        .out_data  (skid_out_s)
    );

    assign out_data_o = skid_out_s[BEAT_W-1 -: DATA_W];
    assign out_last_o = skid_out_s[ID_W];
    assign out_id_o   = skid_out_s[ID_W-1:0];

endmodule

// File: doc/rr_pkt_mux.md
Name: rr_pkt_mux

Overview:
- Downstream consumer of the 4-way round-robin arbiter.
- Presents per-requester packet-valid as the arbiter's request vector, takes the arbiter's one-hot grant, and locks onto the granted requester until its packet's last beat.
- Forwards beats through a registered 2-entry skid output with valid/ready handshake.
- Keeps the arbiter's rotation packet-granular rather than beat-granular.

Parameters:
- NUM_REQ, 4, number of requesters; must match arbiter width.
- DATA_W, 32, payload width per beat.
- MAX_BEATS, 16, beat limit per packet; used only when RR_PKT_MUX_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid_i  input  NUM_REQ  per-requester beat valid.
- in_data_i  input  NUM_REQ*DATA_W  per-requester payload; requester k occupies bits [k*DATA_W +: DATA_W].
- in_last_i  input  NUM_REQ  per-requester last-beat flag.
- in_ready_o  output  NUM_REQ  per-requester beat accept.
- arb_req_o  output  NUM_REQ  request vector to arbiter.
- arb_gnt_i  input  NUM_REQ  one-hot grant from arbiter; combinational from arb_req_o, same cycle.
- out_valid_o  output  1  output beat valid.
- out_ready_i  input  1  downstream accept.
- out_data_o  output  DATA_W  output payload.
- out_last_o  output  1  output last flag.
- out_id_o  output  $clog2(NUM_REQ)  source requester index.

Behaviour:
- Reset is asynchronous, active-high, clock is clk. Reset values: state=IDLE, owner=0, skid empty, out_valid_o=0, out_data_o=0, out_last_o=0, out_id_o=0, in_ready_o=0.
- IDLE
  - arb_req_o = in_valid_i; in_ready_o = 0.
  - If arb_gnt_i != 0: owner_q <= index of lowest set bit; state <= LOCKED.
  - Non-one-hot grant resolves to lowest index.
  - No beat transfers in the grant cycle (1-cycle arbitration bubble).
- LOCKED
  - arb_req_o = 0, so the arbiter's grant output is 0 and its mask holds.
  - in_ready_o[owner] = !skid_full; all other bits 0.
  - A beat transfers when in_valid_i[owner] & in_ready_o[owner].
  - A transferred beat with in_last_i[owner]=1 sets state <= IDLE at the next edge; the next arbitration happens in that IDLE cycle.
  - Owner's in_valid_i low while LOCKED: stay LOCKED, wait indefinitely.
  - Single-beat packet (last on first beat): LOCKED for exactly 1 cycle.
- Skid output (2 entries)
  - A beat accepted at edge N is visible on out_valid_o in cycle N+1.
  - out_* driven only from registers.
  - Full throughput: 1 beat/cycle while out_ready_i=1.
  - out_ready_i=0: first beat parks in the output reg, second in the skid; skid_full then drops in_ready_o.
  - Order preserved. No beat lost or duplicated.
  - out_data_o, out_last_o and out_id_o are stable while out_valid_o=1 & !out_ready_i.
- Throughput: packet of B beats with out_ready_i=1 occupies B+1 cycles on input, including the bubble.
- Reset mid-packet: packet is abandoned, skid contents are discarded, and operation resumes in IDLE.

Optional Feature:
- Macro: RR_PKT_MUX_TIMEOUT_EN.
- Defined:
  - A beat counter counts transferred beats in LOCKED.
  - When the count reaches MAX_BEATS without a last beat, the MAX_BEATS-th beat is forwarded with out_last_o forced to 1 and state returns to IDLE.
  - Sticky output timeout_o (1 bit, reset 0) sets to 1; it is cleared only by reset.
- Undefined: no counter, no timeout_o port; packets of unbounded length are allowed.

Decomposition:
- Package rr_pkt_pkg holds:
  - NUM_REQ_DEF = 4 and DATA_W_DEF = 32;
  - typedef enum logic {IDLE, LOCKED} state_t;
  - struct beat_t {data, last, id}, carried through the skid.
- Sub-module pkt_skid_buf: generic 2-entry valid/ready register slice parameterized on beat_t width. The top level holds the FSM, owner register, input mux and optional counter.

Test Plan:
- Reset then idle: in_valid_i=0 -> out_valid_o=0, arb_req_o=0000, in_ready_o=0000 for 10 cycles.
- Single packet: req 2 sends 3 beats 0xA0, 0xA1, 0xA2(last) with out_ready_i=1 -> grant cycle 0, beats accepted cycles 1-3, out beats cycles 2-4 with out_id_o=2 and last on 0xA2, state IDLE at cycle 4.
- Contention: req 0 and req 3 each send a 2-beat packet, arbiter from reset -> all of req 0 is output before any beat of req 3; arb_req_o=0000 throughout req 0's LOCKED period.
- Backpressure: req 1 sends a 4-beat packet, out_ready_i=0 for cycles 2-5 -> in_ready_o[1] drops after 2 beats are buffered, out_data_o stable while stalled, all 4 beats delivered in order with no duplicates.
- Reset mid-packet: assert reset after beat 2 of a 5-beat packet -> out_valid_o=0 immediately (async), state IDLE after release, next packet from any requester delivered cleanly.
- With RR_PKT_MUX_TIMEOUT_EN and MAX_BEATS=4: 6-beat packet without last -> 4th beat out with out_last_o=1, timeout_o=1, arbitration resumes.
